// File: rtl/irq_ack_ctrl_if.sv
// Bus bundle between the CPU/device daisy chain and the interrupt acknowledge controller.
// The controller connects to the slave modport; the CPU/device side connects to master.
interface irq_ack_ctrl_if;
  logic       irq;
  logic [3:0] vec;
  logic       boundary;
  logic [3:0] pc;
  logic       ei;
  logic       di;
  logic       reti;
  logic       ack;
  logic       take;
  logic [3:0] jump_pc;
  logic       ret;
  logic [3:0] saved_pc;
  logic       ie;
  logic       in_service;
  logic [3:0] spurious;

  modport master (
    output irq, vec, boundary, pc, ei, di, reti,
    input  ack, take, jump_pc, ret, saved_pc, ie, in_service, spurious
  );

  modport slave (
    input  irq, vec, boundary, pc, ei, di, reti,
    output ack, take, jump_pc, ret, saved_pc, ie, in_service, spurious
  );
endinterface

// File: rtl/irq_ack_ctrl.sv
// Single-level interrupt acknowledge controller.
// It samples the daisy chain at instruction boundaries, captures vector and return pc, and sequences take/ret.
module irq_ack_ctrl (
  input  logic          clock,
  input  logic          reset,
  irq_ack_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACK     = 3'd1,
    JUMP    = 3'd2,
    SERVICE = 3'd3,
    RETURN  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       ie_q, ie_d;
  logic [3:0] jump_pc_q, jump_pc_d;
  logic [3:0] saved_pc_q, saved_pc_d;
  logic [3:0] spurious_q, spurious_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ie_q       <= 1'b0;
      jump_pc_q  <= 4'd0;
      saved_pc_q <= 4'd0;
      spurious_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      jump_pc_q  <= jump_pc_d;
      saved_pc_q <= saved_pc_d;
      spurious_q <= spurious_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    jump_pc_d  = jump_pc_q;
    saved_pc_d = saved_pc_q;
    spurious_d = spurious_q;

    case (state_q)
      IDLE: begin
        // ie_q is the pre-update value, so a same-cycle di cannot cancel this entry
        if (bus.irq && ie_q && bus.boundary) begin
          state_d = ACK;
        end
        if (bus.di) begin
          ie_d = 1'b0;
        end else if (bus.ei) begin
          ie_d = 1'b1;
        end
      end
      ACK: begin
        if (bus.irq) begin
          jump_pc_d  = bus.vec;
          saved_pc_d = bus.pc;
          state_d    = JUMP;
        end else begin
          if (spurious_q != 4'hF) begin
            spurious_d = spurious_q + 4'd1;
          end
          state_d = IDLE;
        end
      end
      JUMP: begin
        ie_d    = 1'b0;
        state_d = SERVICE;
      end
      SERVICE: begin
        if (bus.reti) begin
          state_d = RETURN;
        end
      end
      RETURN: begin
        ie_d    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pulses are decoded straight from the state so reset drops them without a clock edge
  assign bus.ack        = (state_q == ACK);
  assign bus.take       = (state_q == JUMP);
  assign bus.ret        = (state_q == RETURN);
  assign bus.in_service = (state_q == SERVICE);
  assign bus.ie         = ie_q;
  assign bus.jump_pc    = jump_pc_q;
  assign bus.saved_pc   = saved_pc_q;
  assign bus.spurious   = spurious_q;

endmodule

// File: doc/irq_ack_ctrl.md
IRQ_ACK_CTRL -- requirements
Module: irq_ack_ctrl

Interface
REQ-001 SHALL have port clock  in  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port irq  in  1  wired interrupt request from the device daisy chain, active-high.
REQ-004 SHALL have port vec  in  4  vector driven by the acknowledged device; valid during ack.
REQ-005 SHALL have port boundary  in  1  CPU instruction-boundary strobe, one cycle.
REQ-006 SHALL have port pc  in  4  current CPU program counter.
REQ-007 SHALL have port ei  in  1  enable-interrupts command pulse.
REQ-008 SHALL have port di  in  1  disable-interrupts command pulse.
REQ-009 SHALL have port reti  in  1  return-from-interrupt command pulse.
REQ-010 SHALL have port ack  out  1  acknowledge to the daisy chain.
REQ-011 SHALL have port take  out  1  one-cycle pulse; CPU loads pc from jump_pc.
REQ-012 SHALL have port jump_pc  out  4  captured vector.
REQ-013 SHALL have port ret  out  1  one-cycle pulse; CPU loads pc from saved_pc.
REQ-014 SHALL have port saved_pc  out  4  pc saved at entry.
REQ-015 SHALL have port ie  out  1  global interrupt enable flag.
REQ-016 SHALL have port in_service  out  1  high while a handler runs.
REQ-017 SHALL have port spurious  out  4  saturating count of spurious acknowledges.

Function
REQ-018 SHALL implement FSM states IDLE, ACK, JUMP, SERVICE, RETURN.
REQ-019 In IDLE, SHALL move to ACK when irq=1, ie=1 and boundary=1 in the same cycle; otherwise stay in IDLE.
REQ-020 In ACK, SHALL drive ack=1 for exactly one cycle.
REQ-020a In ACK with irq still 1, SHALL capture vec into jump_pc and pc into saved_pc, and go to JUMP.
REQ-021 In ACK with irq=0, SHALL capture nothing, increment spurious (saturating at 15), and return to IDLE.
REQ-022 In JUMP, SHALL drive take=1 for one cycle, clear ie, and go to SERVICE.
REQ-023 In SERVICE, SHALL hold in_service=1 and ignore irq.
REQ-023a On reti in SERVICE, SHALL go to RETURN.
REQ-024 In RETURN, SHALL drive ret=1 for one cycle, set ie=1, and go to IDLE.
REQ-025 Interrupt latency: take SHALL assert exactly 2 cycles after the qualifying boundary edge.
REQ-026 ei SHALL set ie on the next edge; di SHALL clear ie on the next edge.
REQ-026a ei and di in the same cycle: di SHALL win.
REQ-027 ei or di in ACK, JUMP or SERVICE SHALL be ignored; the JUMP clear and the RETURN set take priority.
REQ-028 reti outside SERVICE SHALL be ignored and SHALL NOT pulse ret.
REQ-029 ie cleared by di in the same cycle as a qualifying boundary: the entry SHALL still proceed, since ie is sampled before update.
REQ-030 jump_pc and saved_pc SHALL hold their values until the next successful capture.
REQ-031 ack, take and ret SHALL never be high in the same cycle.
REQ-031a ack, take and ret SHALL never be high for two consecutive cycles.
REQ-032 No nesting: a new acknowledge SHALL NOT start before RETURN completes.

Reset
REQ-033 While reset=1, SHALL asynchronously force state IDLE and clear ack, take, ret, in_service and ie.
REQ-033a While reset=1, SHALL asynchronously clear jump_pc, saved_pc and spurious to 0.
REQ-034 Reset asserted in any state, including mid-ACK or SERVICE, SHALL abort the sequence with no ret pulse.
REQ-035 After reset release, ie SHALL remain 0 until an ei pulse.

Verification
REQ-036 Basic entry and return:
- Stimulus: ei, then irq=1, vec=9, pc=3, boundary at cycle N.
- Response: ack at N+1, take at N+2 with jump_pc=9 and saved_pc=3, in_service from N+3.
- Then reti at M: ret at M+1 with saved_pc=3, and ie=1 after.
REQ-037 Masked request: ie=0, irq=1, boundary pulses for 10 cycles -> ack never asserts, state stays IDLE.
REQ-038 Spurious acknowledge:
- Stimulus: irq drops in the ACK cycle.
- Response: spurious 0->1, no take, back to IDLE.
- Repeat 20 times -> spurious saturates at 15.
REQ-039 No nesting: irq held high during SERVICE -> no ack until after the ret pulse; a new entry then follows at the next boundary.
REQ-040 Reset in SERVICE -> in_service=0, ie=0 and jump_pc=0 immediately, without waiting for a clock edge.
REQ-041 Command collisions:
- ei and di in the same cycle -> ie=0.
- reti in IDLE -> no ret pulse.
